mac_accum: RTL and testbench

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_accum.sv | 128 ++++++++++++
 tb/tb_mac_accum.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// Pipelined Q1.15 multiply-accumulate: sums TERMS products per group, then
// rounds half-up and saturates the sum to a 16-bit result.
module mac_accum #(
    parameter int unsigned TERMS     = 16,
    parameter int unsigned FRAC_BITS = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        valid_in,
    output logic [15:0] result_out,
    output logic        valid_out,
    output logic        sat_out,
    output logic [7:0]  term_cnt_out
);

    localparam int unsigned ACC_W = 40;
    localparam logic [7:0] LAST_CNT = 8'(TERMS - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = 40'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_OUT  = 40'sd32767;
    localparam logic signed [ACC_W-1:0] MIN_OUT  = -40'sd32768;

    // stage 1: product register and group tags
    logic        [7:0]       cnt_d, cnt_q;
    logic signed [31:0]      prod_d, prod_q;
    logic                    p_vld_d, p_vld_q;
    logic                    p_first_d, p_first_q;
    logic                    p_last_d, p_last_q;
    // stage 2: accumulator
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    acc_last_d, acc_last_q;
    // stage 3: rounded sum
    logic signed [ACC_W-1:0] rnd_d, rnd_q;
    logic                    rnd_vld_d, rnd_vld_q;
    // stage 4: saturated output
    logic        [15:0]      res_d, res_q;
    logic                    res_vld_d, res_vld_q;
    logic                    sat_d, sat_q;

    always_comb begin
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        p_vld_d   = 1'b0;
        p_first_d = p_first_q;
        p_last_d  = p_last_q;
        if (valid_in) begin
            prod_d    = $signed(a_in) * $signed(b_in);
            p_vld_d   = 1'b1;
            p_first_d = (cnt_q == 8'd0);
            p_last_d  = (cnt_q == LAST_CNT);
            cnt_d     = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        acc_last_d = 1'b0;
        if (p_vld_q) begin
            acc_d      = p_first_q ? {{(ACC_W-32){prod_q[31]}}, prod_q}
                                   : acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
            acc_last_d = p_last_q;
        end
    end

    // acc_q is sampled here while the next group may already be loading it
    always_comb begin
        rnd_d     = rnd_q;
        rnd_vld_d = acc_last_q;
        if (acc_last_q) begin
            rnd_d = (acc_q + RND_HALF) >>> FRAC_BITS;
        end
    end

    always_comb begin
        res_d     = res_q;
        sat_d     = sat_q;
        res_vld_d = rnd_vld_q;
        if (rnd_vld_q) begin
            if (rnd_q > MAX_OUT) begin
                res_d = 16'h7FFF;
                sat_d = 1'b1;
            end else if (rnd_q < MIN_OUT) begin
                res_d = 16'h8000;
                sat_d = 1'b1;
            end else begin
                res_d = rnd_q[15:0];
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            prod_q     <= '0;
            p_vld_q    <= 1'b0;
            p_first_q  <= 1'b0;
            p_last_q   <= 1'b0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            rnd_q      <= '0;
            rnd_vld_q  <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            p_vld_q    <= p_vld_d;
            p_first_q  <= p_first_d;
            p_last_q   <= p_last_d;
            acc_q      <= acc_d;
            acc_last_q <= acc_last_d;
            rnd_q      <= rnd_d;
            rnd_vld_q  <= rnd_vld_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            sat_q      <= sat_d;
        end
    end

    assign result_out   = res_q;
    assign valid_out    = res_vld_q;
    assign sat_out      = sat_q;
    assign term_cnt_out = cnt_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed groups plus random traffic, checked against a
// queue-based model that sums whole groups with plain integer arithmetic.
module tb_mac_accum;

    localparam int TERMS = 16;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        valid_in = 1'b0;
    logic [15:0] result_out;
    logic        valid_out;
    logic        sat_out;
    logic [7:0]  term_cnt_out;

    mac_accum #(.TERMS(TERMS), .FRAC_BITS(15)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .valid_in     (valid_in),
        .result_out   (result_out),
        .valid_out    (valid_out),
        .sat_out      (sat_out),
        .term_cnt_out (term_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        longint      due;
        logic [15:0] res;
        logic        sat;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      edge_n  = 0;
    longint      grp[$];
    exp_t        pend[$];
    logic [15:0] exp_res = '0;
    logic        exp_sat = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, act, exp);
        end
    endtask

    function automatic exp_t finish_group();
        exp_t   e;
        longint sum = 0;
        longint n, q;
        foreach (grp[i]) sum += grp[i];
        n = sum + 16384;
        q = n / 32768;
        if (n < 0 && (n % 32768) != 0) q -= 1;
        e.due = edge_n + 3;
        if (q > 32767) begin
            e.res = 16'h7FFF; e.sat = 1'b1;
        end else if (q < -32768) begin
            e.res = 16'h8000; e.sat = 1'b1;
        end else begin
            e.res = 16'(q); e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b);
        logic vo_exp;
        rst_in   = r;
        valid_in = v;
        a_in     = a;
        b_in     = b;
        @(posedge clk_in);
        edge_n++;
        if (r) begin
            grp.delete();
            pend.delete();
            exp_res = '0;
            exp_sat = 1'b0;
        end else if (v) begin
            grp.push_back(longint'($signed(a)) * longint'($signed(b)));
            if (grp.size() == TERMS) begin
                pend.push_back(finish_group());
                grp.delete();
            end
        end
        #1;
        vo_exp = (pend.size() > 0) && (pend[0].due == edge_n);
        if (vo_exp) begin
            exp_res = pend[0].res;
            exp_sat = pend[0].sat;
            void'(pend.pop_front());
        end
        check("valid_out", 32'(valid_out), 32'(vo_exp));
        check("result_out", 32'(result_out), 32'(exp_res));
        check("sat_out", 32'(sat_out), 32'(exp_sat));
        check("term_cnt_out", 32'(term_cnt_out), 32'(grp.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic run_group(input logic [15:0] a1, input logic [15:0] b1, input bit all_same,
                             input int gap_at, input int gap_n);
        for (int i = 1; i <= TERMS; i++) begin
            if (i == 1 || all_same) step(1'b0, 1'b1, a1, b1);
            else                    step(1'b0, 1'b1, 16'h0000, 16'h0000);
            if (i == gap_at) idle(gap_n);
        end
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0);
        idle(2);

        run_group(16'h3CCC, 16'h3CCC, 1'b0, 0, 0);
        idle(5);
        run_group(16'hC334, 16'h3CCC, 1'b0, 0, 0);
        idle(5);
        run_group(16'h3CCC, 16'h3CCC, 1'b1, 0, 0);
        idle(5);
        run_group(16'h8000, 16'h8000, 1'b0, 0, 0);
        idle(5);

        run_group(16'h3CCC, 16'h3CCC, 1'b0, 0, 0);
        run_group(16'hC334, 16'h3CCC, 1'b0, 0, 0);
        idle(5);

        run_group(16'h3CCC, 16'h3CCC, 1'b0, 8, 3);
        idle(5);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h3CCC, 16'h3CCC);
        step(1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
        run_group(16'h3CCC, 16'h3CCC, 1'b0, 0, 0);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                a = 16'($signed(a) >>> 5);
                b = 16'($signed(b) >>> 5);
            end
            step(($urandom_range(99, 0) == 0), ($urandom_range(9, 0) < 7), a, b);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
